// File: rtl/cpu_fetch_unit.sv
// Instruction/immediate fetch stage: owns the PC, runs the program-RAM read
// handshake and presents fetched bytes to the control FSM with a wait-state timeout.
module cpu_fetch_unit #(
  parameter int unsigned          ADDR_W     = 8,
  parameter logic [ADDR_W-1:0]    RESET_PC   = '0,
  parameter int unsigned          MAX_WAIT   = 15,
  parameter logic [7:0]           NOP_OPCODE = 8'h00
) (
  input  logic              clk,
  input  logic              reset_cycle,
  input  logic              fetch_start,
  input  logic              fetch_imm,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  input  logic              halt,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic [7:0]        instruction,
  output logic [7:0]        imm_data,
  output logic              bus_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE   = 1;
  localparam logic [7:0]        CNT_LAST = 8'(MAX_WAIT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [7:0]        instruction_q, instruction_d;
  logic [7:0]        imm_data_q, imm_data_d;
  logic              bus_ready_q, bus_ready_d;
  logic              timeout_err_q, timeout_err_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              kind_imm_q, kind_imm_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    mem_addr_d    = mem_addr_q;
    mem_rd_d      = mem_rd_q;
    instruction_d = instruction_q;
    imm_data_d    = imm_data_q;
    bus_ready_d   = bus_ready_q;
    timeout_err_d = timeout_err_q;
    cnt_d         = cnt_q;
    kind_imm_d    = kind_imm_q;

    unique case (state_q)
      ST_IDLE, ST_READY: begin
        if (!halt && (fetch_start || fetch_imm)) begin
          kind_imm_d  = !fetch_start;
          mem_addr_d  = pc_q;
          mem_rd_d    = 1'b1;
          bus_ready_d = 1'b0;
          cnt_d       = '0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          if (kind_imm_q) imm_data_d    = mem_rdata;
          else            instruction_d = mem_rdata;
          pc_d        = pc_q + PC_ONE;
          mem_rd_d    = 1'b0;
          bus_ready_d = 1'b1;
          state_d     = ST_READY;
        end else if (cnt_q == CNT_LAST) begin
          if (kind_imm_q) imm_data_d    = '0;
          else            instruction_d = NOP_OPCODE;
          timeout_err_d = 1'b1;
          mem_rd_d      = 1'b0;
          bus_ready_d   = 1'b1;
          state_d       = ST_READY;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A PC load overrides the post-ack increment in the same cycle.
    if (pc_load) pc_d = pc_load_val;
  end

  always_ff @(posedge clk) begin
    if (reset_cycle) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      mem_addr_q    <= RESET_PC;
      mem_rd_q      <= 1'b0;
      instruction_q <= NOP_OPCODE;
      imm_data_q    <= '0;
      bus_ready_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
      kind_imm_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      mem_addr_q    <= mem_addr_d;
      mem_rd_q      <= mem_rd_d;
      instruction_q <= instruction_d;
      imm_data_q    <= imm_data_d;
      bus_ready_q   <= bus_ready_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
      kind_imm_q    <= kind_imm_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_rd      = mem_rd_q;
  assign instruction = instruction_q;
  assign imm_data    = imm_data_q;
  assign bus_ready   = bus_ready_q;
  assign pc          = pc_q;
  assign busy        = (state_q == ST_WAIT);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Directed bench for cpu_fetch_unit with hand-computed expectations.
module tb_cpu_fetch_unit;

  logic       clk = 1'b0;
  logic       reset_cycle = 1'b1;
  logic       fetch_start = 1'b0;
  logic       fetch_imm = 1'b0;
  logic       pc_load = 1'b0;
  logic [7:0] pc_load_val = '0;
  logic       halt = 1'b0;
  logic [7:0] mem_rdata = '0;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] instruction;
  logic [7:0] imm_data;
  logic       bus_ready;
  logic [7:0] pc;
  logic       busy;
  logic       timeout_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  cpu_fetch_unit #(
    .ADDR_W(8),
    .RESET_PC(8'h00),
    .MAX_WAIT(15),
    .NOP_OPCODE(8'h00)
  ) dut (
    .clk(clk),
    .reset_cycle(reset_cycle),
    .fetch_start(fetch_start),
    .fetch_imm(fetch_imm),
    .pc_load(pc_load),
    .pc_load_val(pc_load_val),
    .halt(halt),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .mem_addr(mem_addr),
    .mem_rd(mem_rd),
    .instruction(instruction),
    .imm_data(imm_data),
    .bus_ready(bus_ready),
    .pc(pc),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick(); tick();
    reset_cycle = 1'b0;
    check("rst_pc", pc, 8'h00);
    check("rst_addr", mem_addr, 8'h00);
    check("rst_rd", mem_rd, 0);
    check("rst_instr", instruction, 8'h00);
    check("rst_imm", imm_data, 8'h00);
    check("rst_rdy", bus_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_to", timeout_err, 0);

    // ack outside WAIT is ignored
    mem_ack = 1'b1; mem_rdata = 8'h77;
    tick();
    mem_ack = 1'b0;
    check("idle_ack_instr", instruction, 8'h00);
    check("idle_ack_rdy", bus_ready, 0);

    // zero-wait instruction fetch at 0x10
    pc_load = 1'b1; pc_load_val = 8'h10;
    tick();
    pc_load = 1'b0;
    check("load_pc", pc, 8'h10);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("f1_rd", mem_rd, 1);
    check("f1_addr", mem_addr, 8'h10);
    check("f1_busy", busy, 1);
    check("f1_rdy0", bus_ready, 0);
    mem_ack = 1'b1; mem_rdata = 8'h41;
    tick();
    mem_ack = 1'b0;
    check("f1_instr", instruction, 8'h41);
    check("f1_rdy", bus_ready, 1);
    check("f1_pc", pc, 8'h11);
    check("f1_rd_off", mem_rd, 0);
    check("f1_busy_off", busy, 0);

    // immediate fetch with 3 wait cycles: busy for 4 cycles
    fetch_imm = 1'b1;
    tick();
    fetch_imm = 1'b0;
    check("imm_busy0", busy, 1);
    check("imm_addr", mem_addr, 8'h11);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("imm_busy", busy, 1);
    end
    mem_ack = 1'b1; mem_rdata = 8'h7F;
    tick();
    mem_ack = 1'b0;
    check("imm_data", imm_data, 8'h7F);
    check("imm_instr_keep", instruction, 8'h41);
    check("imm_pc", pc, 8'h12);
    check("imm_rdy", bus_ready, 1);
    check("imm_busy_off", busy, 0);

    // PC wrap from 0xFF
    pc_load = 1'b1; pc_load_val = 8'hFF;
    tick();
    pc_load = 1'b0;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("wrap_addr", mem_addr, 8'hFF);
    mem_ack = 1'b1; mem_rdata = 8'h05;
    tick();
    mem_ack = 1'b0;
    check("wrap_instr", instruction, 8'h05);
    check("wrap_pc", pc, 8'h00);

    // timeout after 15 cycles in WAIT
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      check("to_busy", busy, 1);
    end
    check("to_not_yet", timeout_err, 0);
    tick();
    check("to_instr", instruction, 8'h00);
    check("to_rdy", bus_ready, 1);
    check("to_err", timeout_err, 1);
    check("to_pc", pc, 8'h00);
    check("to_rd", mem_rd, 0);
    check("to_busy_off", busy, 0);
    mem_ack = 1'b1; mem_rdata = 8'hAA;
    tick();
    mem_ack = 1'b0;
    check("late_ack_instr", instruction, 8'h00);
    check("late_ack_pc", pc, 8'h00);
    check("late_ack_rdy", bus_ready, 1);

    // pc_load on the ack edge wins over the increment
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    pc_load = 1'b1; pc_load_val = 8'h30;
    tick();
    mem_ack = 1'b0; pc_load = 1'b0;
    check("ldack_pc", pc, 8'h30);
    check("ldack_instr", instruction, 8'h5A);
    check("to_sticky", timeout_err, 1);

    // fetch_start held through WAIT and a load mid-WAIT
    fetch_start = 1'b1;
    tick();
    check("hold_addr", mem_addr, 8'h30);
    pc_load = 1'b1; pc_load_val = 8'h50;
    tick();
    pc_load = 1'b0;
    check("midld_addr", mem_addr, 8'h30);
    check("midld_pc", pc, 8'h50);
    check("midld_busy", busy, 1);
    mem_ack = 1'b1; mem_rdata = 8'h11;
    tick();
    mem_ack = 1'b0; fetch_start = 1'b0;
    check("midld_instr", instruction, 8'h11);
    check("midld_pc_inc", pc, 8'h51);
    tick();
    check("noqueue_busy", busy, 0);
    check("noqueue_rd", mem_rd, 0);
    check("noqueue_rdy", bus_ready, 1);

    // reset mid-WAIT with a coincident ack
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    reset_cycle = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h99;
    tick();
    reset_cycle = 1'b0; mem_ack = 1'b0;
    check("mrst_rd", mem_rd, 0);
    check("mrst_rdy", bus_ready, 0);
    check("mrst_pc", pc, 8'h00);
    check("mrst_instr", instruction, 8'h00);
    check("mrst_to", timeout_err, 0);
    check("mrst_busy", busy, 0);

    // halt blocks acceptance
    halt = 1'b1; fetch_start = 1'b1;
    tick(); tick();
    check("halt_busy", busy, 0);
    check("halt_rd", mem_rd, 0);
    halt = 1'b0; fetch_start = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_fetch_unit.md
Name: cpu_fetch_unit

Overview:
Instruction and immediate fetch stage sitting directly upstream of the CPU control FSM. Owns the program counter and runs the read handshake to program RAM. Presents the fetched byte on `instruction` or `imm_data` with a level `bus_ready` that the controller polls while in its wait-for-RAM state. Accepts PC loads for JMP/CALL/RET and flags stalled memory with a wait-state timeout.

Parameters:
- ADDR_W, 8, PC and memory address width.
- RESET_PC, 0, PC value after reset.
- MAX_WAIT, 15, maximum cycles spent in WAIT before timeout (1..255).
- NOP_OPCODE, 8'h00, byte substituted on timeout.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_cycle  in  1  synchronous, active-high reset.
- fetch_start  in  1  request instruction fetch at current PC (sampled level).
- fetch_imm  in  1  request immediate-byte fetch at current PC.
- pc_load  in  1  load PC from pc_load_val.
- pc_load_val  in  ADDR_W  new PC value.
- halt  in  1  block acceptance of new requests.
- mem_rdata  in  8  RAM read data, valid when mem_ack=1.
- mem_ack  in  1  RAM read complete.
- mem_addr  out  ADDR_W  RAM address.
- mem_rd  out  1  RAM read strobe (level).
- instruction  out  8  last fetched opcode byte.
- imm_data  out  8  last fetched immediate byte.
- bus_ready  out  1  fetched data valid.
- pc  out  ADDR_W  current program counter.
- busy  out  1  high in WAIT.
- timeout_err  out  1  sticky: a fetch timed out.

Behaviour:
- Reset (synchronous, sampled at clk edge): state=IDLE, pc=RESET_PC, mem_rd=0, mem_addr=RESET_PC, instruction=NOP_OPCODE, imm_data=0, bus_ready=0, busy=0, timeout_err=0, wait counter=0. Overrides everything, including mid-fetch; an ack in the reset cycle is ignored.
- States: IDLE, WAIT, READY.
- Request acceptance:
  - Allowed only in IDLE or READY, and only with halt=0.
  - If fetch_start=1 or fetch_imm=1: latch request kind (fetch_start wins if both are high), mem_addr<=pc, mem_rd<=1, bus_ready<=0, counter<=0, go to WAIT.
- WAIT:
  - mem_rd held 1 and mem_addr held stable.
  - Counter increments each cycle without ack.
  - On mem_ack=1: capture mem_rdata into instruction (fetch kind) or imm_data (imm kind), pc<=pc+1 (mod 2^ADDR_W, wraps all-ones to 0), mem_rd<=0, bus_ready<=1, go to READY.
  - If counter reaches MAX_WAIT with no ack: instruction<=NOP_OPCODE (fetch kind only; imm_data<=0 for imm kind), pc unchanged, timeout_err<=1, mem_rd<=0, bus_ready<=1, go to READY.
  - fetch_start/fetch_imm while in WAIT are ignored; no queueing.
- Latency:
  - Request sampled at edge E0; mem_rd=1 after E0.
  - Zero-wait RAM (ack high the cycle after E0) gives data and bus_ready=1 after E1.
  - Each extra wait cycle adds 1.
- READY: bus_ready stays 1 and data stays stable until a new request is accepted, which clears bus_ready on the same edge.
- pc_load:
  - Takes effect in any state.
  - If pc_load coincides with the ack increment, pc<=pc_load_val (load wins).
  - A load during WAIT does not alter the in-flight mem_addr.
- halt: in-flight WAIT completes normally; no new request is accepted while halt=1.
- mem_ack outside WAIT is ignored.
- busy = (state==WAIT); combinational from state.
- timeout_err is cleared only by reset.

Test Plan:
- Reset, pc_load_val=8'h10 with pc_load pulse, fetch_start; RAM returns 8'h41 with ack one cycle after mem_rd -> mem_addr=8'h10, instruction=8'h41, bus_ready=1 two edges after request, pc=8'h11.
- fetch_imm at pc=8'h11, RAM acks after 3 wait cycles with 8'h7F -> busy high 4 cycles, imm_data=8'h7F, instruction unchanged (8'h41), pc=8'h12.
- PC at 8'hFF, fetch_start, ack data 8'h05 -> instruction=8'h05, pc wraps to 8'h00.
- No ack for MAX_WAIT=15 cycles -> at cycle 15 instruction=8'h00, bus_ready=1, timeout_err=1, pc unchanged, mem_rd=0; a later ack pulse is ignored.
- pc_load=1 with pc_load_val=8'h30 on the ack edge -> pc=8'h30 (not incremented value), data still captured. Separately, fetch_start during WAIT -> no second request.
- reset_cycle asserted mid-WAIT with ack in the same cycle -> next cycle mem_rd=0, bus_ready=0, pc=RESET_PC, instruction=8'h00. halt=1 with fetch_start -> stays IDLE, mem_rd=0.
